demux_1x4_rr_dispatcher: RTL and testbench

// - Sequences a 1x4 demultiplexing path: takes one valid/ready input stream and

---
 rtl/demux_1x4_rr_dispatcher.sv | 107 ++++++++++
 tb/tb_demux_1x4_rr_dispatcher.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x4_rr_dispatcher.sv
// ---------------------------------------------------------------------------
// demux_1x4_rr_dispatcher
//   Takes one valid/ready input stream and dispatches each accepted word to
//   one of four 1-deep output registers in round-robin order. A channel is
//   skipped while it is masked off, or while it is occupied and not draining.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   en_mask    per-channel dispatch enable (bit i = channel i)
//   in_valid   producer word valid
//   in_ready   dispatcher can accept this cycle (combinational)
//   in_data    producer word
//   out_valid  channel i holds a word
//   out_ready  consumer i takes its word this cycle
//   out_data   channel i word at [i*DATA_W +: DATA_W]
//   sel        channel index of the most recent dispatch
//   acc_cnt    words accepted since reset (wraps)
// ---------------------------------------------------------------------------
module demux_1x4_rr_dispatcher #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          en_mask,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [1:0]          sel,
  output logic [CNT_W-1:0]    acc_cnt
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned PTR_W = 2;

  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_sel;
  logic [NCH-1:0]    r_valid;
  logic [DATA_W-1:0] r_data [NCH];
  logic [CNT_W-1:0]  r_cnt;

  logic [NCH-1:0]    w_free;
  logic              w_found;
  logic [PTR_W-1:0]  w_ch;
  logic [PTR_W-1:0]  w_idx;
  logic              w_accept;

  // A draining slot is reusable in the same cycle, giving 1 word/cycle per channel.
  assign w_free   = en_mask & (~r_valid | out_ready);
  assign in_ready = |w_free;
  assign w_accept = in_valid & in_ready;

  // First free channel searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    w_found = 1'b0;
    w_ch    = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < NCH; k++) begin
      w_idx = r_ptr + PTR_W'(k);
      if (!w_found && w_free[w_idx]) begin
        w_found = 1'b1;
        w_ch    = w_idx;
      end
    end
  end

  // Channel registers, pointer, select and accept counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_data[i] <= '0;
      end
      r_sel <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // A load wins over a drain, so a reloaded channel stays valid.
        if (w_accept && (w_ch == PTR_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= in_data;
        end else if (r_valid[i] && out_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
      if (w_accept) begin
        r_sel <= w_ch;
        r_ptr <= w_ch + PTR_W'(1);
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_valid;
  assign sel       = r_sel;
  assign acc_cnt   = r_cnt;

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign out_data[g*DATA_W +: DATA_W] = r_data[g];
  end

endmodule

// File: tb/tb_demux_1x4_rr_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_demux_1x4_rr_dispatcher
//   Directed bench for the 1x4 round-robin dispatcher. A second instance with
//   a 4-bit counter shares all inputs and is used for the counter wrap case.
// ---------------------------------------------------------------------------
module tb_demux_1x4_rr_dispatcher;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en_mask;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [3:0]  out_ready;

  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [1:0]  sel;
  logic [15:0] acc_cnt;

  logic        in_ready4;
  logic [3:0]  out_valid4;
  logic [31:0] out_data4;
  logic [1:0]  sel4;
  logic [3:0]  acc_cnt4;

  int n_tests;
  int n_fail;

  demux_1x4_rr_dispatcher #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en_mask(en_mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .acc_cnt(acc_cnt)
  );

  demux_1x4_rr_dispatcher #(.DATA_W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en_mask(en_mask),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .sel(sel4), .acc_cnt(acc_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en_mask   = 4'hF;
    out_ready = 4'hF;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    do_reset();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 4'h0) begin n_fail++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
    n_tests++;
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_tests++;
    if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    n_tests++;
    if (acc_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_acc_cnt got=%0d exp=0", acc_cnt); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_rr_basic();
    int ch;
    logic [7:0] got;
    en_mask   = 4'hF;
    out_ready = 4'hF;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h10 + 8'(i);
      ch = i % 4;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rr_in_ready[%0d] got=%b exp=1", i, in_ready); end
      tick();
      got = out_data[ch*8 +: 8];
      n_tests++;
      if (out_valid !== (4'b0001 << ch)) begin n_fail++; $display("FAIL rr_out_valid[%0d] got=%b exp=%b", i, out_valid, 4'b0001 << ch); end
      n_tests++;
      if (got !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL rr_out_data[%0d] got=%h exp=%h", i, got, 8'h10 + 8'(i)); end
      n_tests++;
      if (sel !== 2'(ch)) begin n_fail++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", i, sel, ch); end
      n_tests++;
      if (acc_cnt !== 16'(i + 1)) begin n_fail++; $display("FAIL rr_acc_cnt[%0d] got=%0d exp=%0d", i, acc_cnt, i + 1); end
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 4'h0) begin n_fail++; $display("FAIL rr_drain got=%b exp=0000", out_valid); end
    n_tests++;
    if (acc_cnt !== 16'd5) begin n_fail++; $display("FAIL rr_acc_idle got=%0d exp=5", acc_cnt); end
  endtask

  task automatic test_mask();
    int ch;
    logic [7:0] got;
    en_mask   = 4'b1010;
    out_ready = 4'hF;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h50 + 8'(i);
      ch = (i % 2 == 0) ? 1 : 3;
      tick();
      got = out_data[ch*8 +: 8];
      n_tests++;
      if (out_valid !== (4'b0001 << ch)) begin n_fail++; $display("FAIL mask_out_valid[%0d] got=%b exp=%b", i, out_valid, 4'b0001 << ch); end
      n_tests++;
      if ((out_valid & 4'b0101) !== 4'b0000) begin n_fail++; $display("FAIL mask_masked_ch[%0d] got=%b exp=0000", i, out_valid & 4'b0101); end
      n_tests++;
      if (got !== 8'h50 + 8'(i)) begin n_fail++; $display("FAIL mask_out_data[%0d] got=%h exp=%h", i, got, 8'h50 + 8'(i)); end
      n_tests++;
      if (sel !== 2'(ch)) begin n_fail++; $display("FAIL mask_sel[%0d] got=%0d exp=%0d", i, sel, ch); end
    end
    n_tests++;
    if (acc_cnt !== 16'd9) begin n_fail++; $display("FAIL mask_acc_cnt got=%0d exp=9", acc_cnt); end
    in_valid = 1'b0;
    en_mask  = 4'hF;
    tick();
  endtask

  task automatic test_hold();
    int exp_ch [6] = '{1, 2, 3, 0, 2, 3};
    int ch;
    logic [7:0] got;
    do_reset();
    en_mask   = 4'hF;
    out_ready = 4'hF;
    in_valid  = 1'b1;
    in_data   = 8'h20;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 4'b1101;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'h30 + 8'(i);
      ch = exp_ch[i];
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_in_ready[%0d] got=%b exp=1", i, in_ready); end
      tick();
      got = out_data[ch*8 +: 8];
      n_tests++;
      if (sel !== 2'(ch)) begin n_fail++; $display("FAIL hold_sel[%0d] got=%0d exp=%0d", i, sel, ch); end
      n_tests++;
      if (got !== 8'h30 + 8'(i)) begin n_fail++; $display("FAIL hold_out_data[%0d] got=%h exp=%h", i, got, 8'h30 + 8'(i)); end
      n_tests++;
      if (out_valid !== ((4'b0001 << ch) | 4'b0010)) begin n_fail++; $display("FAIL hold_out_valid[%0d] got=%b exp=%b", i, out_valid, (4'b0001 << ch) | 4'b0010); end
      n_tests++;
      if (out_data[15:8] !== 8'h30) begin n_fail++; $display("FAIL hold_ch1_stable[%0d] got=%h exp=30", i, out_data[15:8]); end
    end
    n_tests++;
    if (acc_cnt !== 16'd7) begin n_fail++; $display("FAIL hold_acc_cnt got=%0d exp=7", acc_cnt); end
    in_valid  = 1'b0;
    out_ready = 4'hF;
    tick();
    n_tests++;
    if (out_valid !== 4'h0) begin n_fail++; $display("FAIL hold_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en_mask   = 4'hF;
    out_ready = 4'h0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h40 + 8'(i);
      tick();
      n_tests++;
      if (out_valid !== 4'((1 << (i + 1)) - 1)) begin n_fail++; $display("FAIL bp_fill[%0d] got=%b exp=%b", i, out_valid, 4'((1 << (i + 1)) - 1)); end
    end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
    in_data = 8'hEE;
    tick();
    n_tests++;
    if (acc_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_full_acc got=%0d exp=4", acc_cnt); end
    n_tests++;
    if (out_data !== 32'h43424140) begin n_fail++; $display("FAIL bp_full_data got=%h exp=43424140", out_data); end
    out_ready = 4'b0100;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_same_cycle got=%b exp=1", in_ready); end
    in_data = 8'hA5;
    tick();
    n_tests++;
    if (out_valid !== 4'hF) begin n_fail++; $display("FAIL bp_reload_valid got=%b exp=1111", out_valid); end
    n_tests++;
    if (out_data[23:16] !== 8'hA5) begin n_fail++; $display("FAIL bp_reload_data got=%h exp=a5", out_data[23:16]); end
    n_tests++;
    if (sel !== 2'd2) begin n_fail++; $display("FAIL bp_reload_sel got=%0d exp=2", sel); end
    n_tests++;
    if (acc_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_reload_acc got=%0d exp=5", acc_cnt); end
  endtask

  task automatic test_mask_zero_and_reset();
    out_ready = 4'h0;
    en_mask   = 4'h0;
    in_valid  = 1'b1;
    in_data   = 8'h66;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mz_in_ready got=%b exp=0", in_ready); end
    tick();
    n_tests++;
    if (acc_cnt !== 16'd5) begin n_fail++; $display("FAIL mz_acc_hold got=%0d exp=5", acc_cnt); end
    out_ready = 4'b0001;
    tick();
    n_tests++;
    if (out_valid !== 4'b1110) begin n_fail++; $display("FAIL mz_drain got=%b exp=1110", out_valid); end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mz_in_ready_after_drain got=%b exp=0", in_ready); end
    out_ready = 4'h0;
    en_mask   = 4'hF;
    in_data   = 8'h77;
    tick();
    n_tests++;
    if (sel !== 2'd0 || out_valid !== 4'hF || out_data[7:0] !== 8'h77) begin
      n_fail++; $display("FAIL mz_refill got sel=%0d valid=%b d0=%h exp sel=0 valid=1111 d0=77", sel, out_valid, out_data[7:0]);
    end
    do_reset();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 4'h0) begin n_fail++; $display("FAIL mz_rst_valid got=%b exp=0000", out_valid); end
    n_tests++;
    if (sel !== 2'd0) begin n_fail++; $display("FAIL mz_rst_sel got=%0d exp=0", sel); end
    n_tests++;
    if (acc_cnt !== 16'd0) begin n_fail++; $display("FAIL mz_rst_acc got=%0d exp=0", acc_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    en_mask   = 4'hF;
    out_ready = 4'hF;
    in_valid  = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      in_data = 8'(i);
      tick();
      if (i == 15) begin
        n_tests++;
        if (acc_cnt4 !== 4'd15) begin n_fail++; $display("FAIL wrap_15 got=%0d exp=15", acc_cnt4); end
      end
      if (i == 16) begin
        n_tests++;
        if (acc_cnt4 !== 4'd0) begin n_fail++; $display("FAIL wrap_16 got=%0d exp=0", acc_cnt4); end
      end
    end
    n_tests++;
    if (acc_cnt4 !== 4'd1) begin n_fail++; $display("FAIL wrap_17 got=%0d exp=1", acc_cnt4); end
    n_tests++;
    if (acc_cnt !== 16'd17) begin n_fail++; $display("FAIL wrap_wide_17 got=%0d exp=17", acc_cnt); end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    en_mask   = 4'hF;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 4'hF;
    test_reset();
    test_rr_basic();
    test_mask();
    test_hold();
    test_back_to_back();
    test_mask_zero_and_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
